// File: rtl/digital_clock_multi_alarm.sv
// Multi-alarm BCD digital clock: HH:MM:SS time base with an internal prescaler,
// 12/24-hour display, load validation and NUM_ALARMS alarm slots with snooze.
module digital_clock_multi_alarm #(
  parameter int CLK_DIV    = 1,
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_MIN = 5,
  parameter int AW         = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic                  load,
  input  logic [7:0]            hh_in,
  input  logic [7:0]            mm_in,
  input  logic [7:0]            ss_in,
  input  logic                  alarm_wr,
  input  logic [AW-1:0]         alarm_idx,
  input  logic                  alarm_en_in,
  input  logic                  stop_alarm,
  input  logic                  snooze,
  input  logic                  mode_12h,
  output logic [7:0]            hh,
  output logic [7:0]            mm,
  output logic [7:0]            ss,
  output logic                  pm,
  output logic                  tick,
  output logic                  load_err,
  output logic                  alarm,
  output logic [NUM_ALARMS-1:0] alarm_src
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(CLK_DIV - 1);

  typedef enum logic [1:0] {S_OFF, S_ARMED, S_RING, S_SNOOZE} slot_state_t;

  logic [PW-1:0] prescale;
  logic [7:0]    hh_r, mm_r, ss_r;
  logic [23:0]   cur_time;
  logic          time_changed;
  logic          in_valid, load_ok, wr_ok;

  slot_state_t   state      [NUM_ALARMS];
  logic [23:0]   target     [NUM_ALARMS];
  logic [23:0]   snz_target [NUM_ALARMS];

  function automatic logic bcd_valid(input logic [7:0] h, input logic [7:0] m,
                                     input logic [7:0] s);
    return (h[3:0] <= 4'd9) && (m[3:0] <= 4'd9) && (s[3:0] <= 4'd9) &&
           (m[7:4] <= 4'd5) && (s[7:4] <= 4'd5) && (h <= 8'h23);
  endfunction

  function automatic logic [7:0] bcd_to_bin(input logic [7:0] b);
    return 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
  endfunction

  function automatic logic [7:0] bin_to_bcd(input logic [7:0] v);
    return {4'(v / 8'd10), 4'(v % 8'd10)};
  endfunction

  function automatic logic [7:0] digit_inc(input logic [7:0] b);
    return (b[3:0] == 4'd9) ? {b[7:4] + 4'd1, 4'd0} : {b[7:4], b[3:0] + 4'd1};
  endfunction

  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [7:0] h, m, s;
    logic       cs, cm;
    {h, m, s} = t;
    cs = (s == 8'h59);
    cm = cs && (m == 8'h59);
    s = cs ? 8'h00 : digit_inc(s);
    if (cs) m = (m == 8'h59) ? 8'h00 : digit_inc(m);
    if (cm) h = (h == 8'h23) ? 8'h00 : digit_inc(h);
    return {h, m, s};
  endfunction

  // Minutes are added in binary, then folded back into BCD modulo 24 h.
  function automatic logic [23:0] snooze_time(input logic [23:0] t);
    logic [7:0] hb, mb;
    hb = bcd_to_bin(t[23:16]);
    mb = bcd_to_bin(t[15:8]) + 8'(SNOOZE_MIN);
    if (mb >= 8'd60) begin
      mb = mb - 8'd60;
      hb = hb + 8'd1;
    end
    if (hb >= 8'd24) hb = hb - 8'd24;
    return {bin_to_bcd(hb), bin_to_bcd(mb), t[7:0]};
  endfunction

  assign cur_time = {hh_r, mm_r, ss_r};
  assign in_valid = bcd_valid(hh_in, mm_in, ss_in);
  assign load_ok  = load && in_valid;
  assign wr_ok    = alarm_wr && in_valid;

  // Time base: a valid load beats the prescaler; an invalid load is only flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prescale     <= '0;
      hh_r         <= 8'h00;
      mm_r         <= 8'h00;
      ss_r         <= 8'h00;
      tick         <= 1'b0;
      load_err     <= 1'b0;
      time_changed <= 1'b0;
    end else begin
      tick         <= 1'b0;
      time_changed <= 1'b0;
      load_err     <= (load || alarm_wr) && !in_valid;
      if (load_ok) begin
        {hh_r, mm_r, ss_r} <= {hh_in, mm_in, ss_in};
        prescale           <= '0;
        time_changed       <= 1'b1;
      end else if (ena) begin
        if (prescale == PS_LAST) begin
          prescale           <= '0;
          {hh_r, mm_r, ss_r} <= bcd_inc(cur_time);
          tick               <= 1'b1;
          time_changed       <= 1'b1;
        end else begin
          prescale <= prescale + PW'(1);
        end
      end
    end
  end

  // Alarm slots: a write overrides everything, then stop, snooze, and match on the fresh time.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        state[i]      <= S_OFF;
        target[i]     <= '0;
        snz_target[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_ALARMS; i++) begin
        if (wr_ok && (int'(alarm_idx) == i)) begin
          target[i] <= {hh_in, mm_in, ss_in};
          state[i]  <= alarm_en_in ? S_ARMED : S_OFF;
        end else begin
          case (state[i])
            S_ARMED: begin
              if (time_changed && (cur_time == target[i])) state[i] <= S_RING;
            end
            S_RING: begin
              if (stop_alarm) begin
                state[i] <= S_ARMED;
              end else if (snooze) begin
                state[i]      <= S_SNOOZE;
                snz_target[i] <= snooze_time(cur_time);
              end
            end
            S_SNOOZE: begin
              if (stop_alarm) begin
                state[i] <= S_ARMED;
              end else if (time_changed &&
                           ((cur_time == snz_target[i]) || (cur_time == target[i]))) begin
                state[i] <= S_RING;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Ring flags decoded straight from the slot state registers.
  always_comb begin
    alarm_src = '0;
    for (int i = 0; i < NUM_ALARMS; i++) alarm_src[i] = (state[i] == S_RING);
  end

  assign alarm = |alarm_src;
  assign mm    = mm_r;
  assign ss    = ss_r;

  // 12-hour view maps 00 to 12 AM and 13-23 down by twelve with PM set.
  always_comb begin
    hh = hh_r;
    pm = 1'b0;
    if (mode_12h) begin
      if (hh_r == 8'h00) begin
        hh = 8'h12;
      end else if (hh_r == 8'h12) begin
        pm = 1'b1;
      end else if (hh_r > 8'h12) begin
        hh = bin_to_bcd(bcd_to_bin(hh_r) - 8'd12);
        pm = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_digital_clock_multi_alarm.sv
// Self-checking bench for digital_clock_multi_alarm: directed scenarios plus a
// randomized phase, all compared against a seconds-of-day reference model.
module tb_digital_clock_multi_alarm;

  localparam int CLK_DIV    = 2;
  localparam int NUM_ALARMS = 4;
  localparam int SNOOZE_MIN = 5;
  localparam int AW         = 2;
  localparam int DAY        = 86400;
  localparam int OFF = 0, ARMED = 1, RING = 2, SNZ = 3;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  ena;
  logic                  load;
  logic [7:0]            hh_in, mm_in, ss_in;
  logic                  alarm_wr;
  logic [AW-1:0]         alarm_idx;
  logic                  alarm_en_in;
  logic                  stop_alarm;
  logic                  snooze;
  logic                  mode_12h;
  logic [7:0]            hh, mm, ss;
  logic                  pm, tick, load_err, alarm;
  logic [NUM_ALARMS-1:0] alarm_src;

  int vectors     = 0;
  int miscompares = 0;

  int m_sec, m_pres;
  bit m_changed, m_tick, m_err;
  int m_st  [NUM_ALARMS];
  int m_tgt [NUM_ALARMS];
  int m_snz [NUM_ALARMS];

  digital_clock_multi_alarm #(
    .CLK_DIV(CLK_DIV), .NUM_ALARMS(NUM_ALARMS), .SNOOZE_MIN(SNOOZE_MIN), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .ena(ena), .load(load),
    .hh_in(hh_in), .mm_in(mm_in), .ss_in(ss_in),
    .alarm_wr(alarm_wr), .alarm_idx(alarm_idx), .alarm_en_in(alarm_en_in),
    .stop_alarm(stop_alarm), .snooze(snooze), .mode_12h(mode_12h),
    .hh(hh), .mm(mm), .ss(ss), .pm(pm), .tick(tick), .load_err(load_err),
    .alarm(alarm), .alarm_src(alarm_src)
  );

  // Free-running 100 MHz style clock.
  always #5 clk = ~clk;

  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic bit in_valid();
    int h, m, s;
    if (hh_in[3:0] > 9 || hh_in[7:4] > 9 || mm_in[3:0] > 9 || mm_in[7:4] > 9 ||
        ss_in[3:0] > 9 || ss_in[7:4] > 9) return 1'b0;
    h = int'(hh_in[7:4]) * 10 + int'(hh_in[3:0]);
    m = int'(mm_in[7:4]) * 10 + int'(mm_in[3:0]);
    s = int'(ss_in[7:4]) * 10 + int'(ss_in[3:0]);
    return (h < 24) && (m < 60) && (s < 60);
  endfunction

  function automatic int in_sec();
    return (int'(hh_in[7:4]) * 10 + int'(hh_in[3:0])) * 3600 +
           (int'(mm_in[7:4]) * 10 + int'(mm_in[3:0])) * 60 +
           (int'(ss_in[7:4]) * 10 + int'(ss_in[3:0]));
  endfunction

  task automatic set_time_sec(input int sec);
    hh_in = to_bcd(sec / 3600);
    mm_in = to_bcd((sec / 60) % 60);
    ss_in = to_bcd(sec % 60);
  endtask

  task automatic model_reset();
    m_sec = 0; m_pres = 0; m_changed = 0; m_tick = 0; m_err = 0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      m_st[i] = OFF; m_tgt[i] = 0; m_snz[i] = 0;
    end
  endtask

  task automatic model_step();
    bit v;
    if (!reset) begin
      model_reset();
      return;
    end
    v      = in_valid();
    m_err  = (load || alarm_wr) && !v;
    m_tick = 0;
    for (int i = 0; i < NUM_ALARMS; i++) begin
      if (alarm_wr && v && int'(alarm_idx) == i) begin
        m_tgt[i] = in_sec();
        m_st[i]  = alarm_en_in ? ARMED : OFF;
      end else if ((m_st[i] == RING || m_st[i] == SNZ) && stop_alarm) begin
        m_st[i] = ARMED;
      end else if (m_st[i] == RING && snooze) begin
        m_st[i]  = SNZ;
        m_snz[i] = (m_sec + SNOOZE_MIN * 60) % DAY;
      end else if (m_changed && m_st[i] == ARMED && m_sec == m_tgt[i]) begin
        m_st[i] = RING;
      end else if (m_changed && m_st[i] == SNZ && (m_sec == m_snz[i] || m_sec == m_tgt[i])) begin
        m_st[i] = RING;
      end
    end
    m_changed = 0;
    if (load && v) begin
      m_sec = in_sec(); m_pres = 0; m_changed = 1;
    end else if (ena) begin
      if (m_pres == CLK_DIV - 1) begin
        m_pres = 0; m_sec = (m_sec + 1) % DAY; m_tick = 1; m_changed = 1;
      end else begin
        m_pres++;
      end
    end
  endtask

  function automatic logic [31:0] exp_vec();
    int h, mi, s, hd;
    logic p;
    logic [NUM_ALARMS-1:0] src;
    h  = m_sec / 3600;
    mi = (m_sec / 60) % 60;
    s  = m_sec % 60;
    hd = h;
    p  = 1'b0;
    if (mode_12h) begin
      hd = (h % 12 == 0) ? 12 : h % 12;
      p  = (h >= 12);
    end
    src = '0;
    for (int i = 0; i < NUM_ALARMS; i++) src[i] = (m_st[i] == RING);
    return {to_bcd(hd), to_bcd(mi), to_bcd(s), p, m_tick, m_err, |src, src};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_output(input string tag);
    check_val(tag, {hh, mm, ss, pm, tick, load_err, alarm, alarm_src}, exp_vec());
  endtask

  task automatic apply_stimulus(input string tag);
    @(posedge clk);
    model_step();
    #1;
    check_output(tag);
    load = 0; alarm_wr = 0; stop_alarm = 0; snooze = 0;
  endtask

  task automatic run_until_time(input string tag, input logic [23:0] t, input int max);
    bit found = 0;
    for (int k = 0; k < max && !found; k++) begin
      apply_stimulus(tag);
      found = ({hh, mm, ss} === t);
    end
    check_val(tag, 32'(found), 32'd1);
  endtask

  task automatic run_until_alarm(input string tag, input int max);
    bit found = 0;
    for (int k = 0; k < max && !found; k++) begin
      apply_stimulus(tag);
      found = (alarm === 1'b1);
    end
    check_val(tag, 32'(found), 32'd1);
  endtask

  task automatic write_slot(input int idx, input int sec, input bit en);
    alarm_wr = 1; alarm_idx = AW'(idx); alarm_en_in = en;
    set_time_sec(sec);
    apply_stimulus("alarm_wr");
  endtask

  task automatic corrupt_inputs();
    case ($urandom_range(0, 3))
      0:       hh_in = 8'h24;
      1:       mm_in = 8'h5A;
      2:       ss_in = 8'h60;
      default: hh_in = 8'h0C;
    endcase
  endtask

  // Directed scenarios followed by randomized traffic, then an async reset mid-ring.
  initial begin
    int r;
    reset = 0; ena = 0; load = 0; alarm_wr = 0; alarm_idx = '0; alarm_en_in = 0;
    stop_alarm = 0; snooze = 0; mode_12h = 1; hh_in = 0; mm_in = 0; ss_in = 0;
    model_reset();

    $display("[TB] reset");
    apply_stimulus("reset0");
    apply_stimulus("reset1");
    check_val("rst_hh12", 32'({hh, pm, alarm, alarm_src}), 32'({8'h12, 1'b0, 1'b0, 4'b0000}));
    reset = 1; mode_12h = 0; ena = 1;

    $display("[TB] rollovers");
    load = 1; set_time_sec(50);
    apply_stimulus("load_0050");
    run_until_time("roll_min", 24'h000100, 30);
    load = 1; set_time_sec(59 * 60 + 55);
    apply_stimulus("load_5955");
    run_until_time("roll_hour", 24'h010000, 20);
    load = 1; set_time_sec(DAY - 5);
    apply_stimulus("load_235955");
    run_until_time("roll_day", 24'h000000, 20);
    check_val("roll_day_tick", 32'(tick), 32'd1);

    $display("[TB] load priority and validation");
    for (int k = 0; k < CLK_DIV && m_pres != CLK_DIV - 1; k++) apply_stimulus("align");
    load = 1; hh_in = 8'h12; mm_in = 8'h34; ss_in = 8'h56;
    apply_stimulus("load_on_tick");
    check_val("load_prio", 32'({hh, mm, ss, tick}), 32'({24'h123456, 1'b0}));
    ena = 0;
    load = 1; hh_in = 8'h24; mm_in = 8'h00; ss_in = 8'h00;
    apply_stimulus("bad_hh");
    check_val("bad_hh_err", 32'({load_err, hh, mm, ss}), 32'({1'b1, 24'h123456}));
    load = 1; hh_in = 8'h00; mm_in = 8'h5A; ss_in = 8'h00;
    apply_stimulus("bad_mm");
    check_val("bad_mm_err", 32'({load_err, hh, mm, ss}), 32'({1'b1, 24'h123456}));
    alarm_wr = 1; alarm_idx = 0; alarm_en_in = 1; hh_in = 8'h00; mm_in = 8'h00; ss_in = 8'h7F;
    apply_stimulus("bad_wr");
    check_val("bad_wr_err", 32'(load_err), 32'd1);

    $display("[TB] 12h display");
    mode_12h = 1;
    load = 1; set_time_sec(15 * 60);
    apply_stimulus("d_0015");
    check_val("h12_midnight", 32'({hh, pm}), 32'({8'h12, 1'b0}));
    load = 1; set_time_sec(12 * 3600);
    apply_stimulus("d_1200");
    check_val("h12_noon", 32'({hh, pm}), 32'({8'h12, 1'b1}));
    load = 1; set_time_sec(13 * 3600 + 5 * 60);
    apply_stimulus("d_1305");
    check_val("h12_pm1", 32'({hh, pm}), 32'({8'h01, 1'b1}));
    mode_12h = 0;
    apply_stimulus("d_24h");
    check_val("h24_13", 32'({hh, pm}), 32'({8'h13, 1'b0}));

    $display("[TB] multi alarm");
    write_slot(0, 5, 1);
    write_slot(2, 5, 1);
    write_slot(1, 3, 0);
    write_slot(3, 0, 0);
    load = 1; set_time_sec(0);
    apply_stimulus("load_0");
    ena = 1;
    run_until_time("reach_05", 24'h000005, 40);
    ena = 0;
    apply_stimulus("ring_05");
    check_val("src_0101", 32'(alarm_src), 32'b0101);
    stop_alarm = 1;
    apply_stimulus("stop");
    for (int k = 0; k < 3; k++) apply_stimulus("hold_05");
    check_val("no_retrigger", 32'({alarm, alarm_src}), 32'd0);

    $display("[TB] snooze");
    write_slot(2, 5, 0);
    write_slot(0, 23 * 3600 + 58 * 60 + 10, 1);
    load = 1; set_time_sec(23 * 3600 + 58 * 60 + 5);
    ena = 1;
    apply_stimulus("load_2358");
    run_until_alarm("ring_2358", 30);
    check_val("src_0001", 32'(alarm_src), 32'b0001);
    snooze = 1;
    apply_stimulus("snooze");
    check_val("snoozed_quiet", 32'(alarm), 32'd0);
    run_until_alarm("ring_snz", 1000);
    check_val("snz_time", 32'({hh, mm, ss}), 32'(24'h000310));
    stop_alarm = 1; snooze = 1;
    apply_stimulus("stop_and_snooze");
    check_val("stop_wins", 32'(alarm), 32'd0);
    for (int k = 0; k < 10; k++) apply_stimulus("after_stop");

    $display("[TB] random");
    for (int n = 0; n < 3000; n++) begin
      ena = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) mode_12h = ~mode_12h;
      r = int'($urandom_range(0, 99));
      if (r < 4) begin
        load = 1;
        set_time_sec(int'($urandom_range(0, DAY - 1)));
      end else if (r < 12) begin
        alarm_wr    = 1;
        alarm_idx   = AW'($urandom_range(0, NUM_ALARMS - 1));
        alarm_en_in = ($urandom_range(0, 3) != 0);
        set_time_sec((m_sec + int'($urandom_range(1, 20))) % DAY);
      end
      if (r < 12 && $urandom_range(0, 5) == 0) corrupt_inputs();
      stop_alarm = ($urandom_range(0, 39) == 0);
      snooze     = ($urandom_range(0, 14) == 0);
      apply_stimulus("rand");
    end

    $display("[TB] async reset mid-ring");
    mode_12h = 0; ena = 1;
    write_slot(1, (m_sec + 2) % DAY, 1);
    run_until_alarm("ring_pre_rst", 20);
    #3 reset = 0;
    #1;
    check_val("async_rst", 32'({hh, mm, ss, alarm, alarm_src}), 32'd0);
    model_reset();
    check_output("async_rst_model");
    #2 reset = 1;
    for (int k = 0; k < 10; k++) apply_stimulus("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
